nonlinear_part: RTL and testbench

Iterative generator of the 56 nonlinear (AND-monomial) terms of the decomposed 4-bit carry-lookahead adder. It accepts operands a, b, c_in over a valid/ready handshake and expands the carry recurrence one bit level per clock into the algebraic-normal-form product terms. The resulting n vector, together with registered copies of the operands, feeds `linear_part`, which XOR-reduces the terms into s and c_out.

---
 rtl/nl_pkg.sv | 24 ++
 rtl/nl_level_expand.sv | 26 ++
 rtl/nonlinear_part.sv | 120 ++++++++++++
 tb/tb_nonlinear_part.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nl_pkg.sv
// Shared constants, level geometry and FSM state type for the
// carry-lookahead nonlinear-term generator.
package nl_pkg;

  localparam int NBIT_DFLT = 4;
  localparam int NNL_DFLT  = 56;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Offset of level k's terms inside n.
  function automatic int lvl_off(input int k);
    return 2 ** (k + 2) - 4 - k;
  endfunction

  // Number of terms produced at level k; level -1 is the lone c_in term.
  function automatic int lvl_len(input int k);
    return (k < 0) ? 1 : 2 ** (k + 2) - 1;
  endfunction

  function automatic int nnl_for(input int nbit);
    return 2 ** (nbit + 2) - nbit - 4;
  endfunction

endpackage

// File: rtl/nl_level_expand.sv
// Expands one carry level: [a&b, a&t_0.., b&t_0..] from the previous-level terms.
module nl_level_expand #(
  parameter int PREV_W = 31,
  parameter int LEN_W  = $clog2(PREV_W + 1)
) (
  input  logic              a_k,
  input  logic              b_k,
  input  logic [PREV_W-1:0] prev,
  input  logic [LEN_W-1:0]  prev_len,
  output logic [PREV_W-1:0] terms
);

  logic [PREV_W-1:0] keep;
  logic [PREV_W-1:0] a_part;
  logic [PREV_W-1:0] b_part;
  logic [LEN_W:0]    b_shift;

  // Bits of prev above prev_len are stale and must never reach the output.
  assign keep    = ~({PREV_W{1'b1}} << prev_len);
  assign a_part  = {PREV_W{a_k}} & prev & keep;
  assign b_part  = {PREV_W{b_k}} & prev & keep;
  assign b_shift = (LEN_W + 1)'(prev_len) + (LEN_W + 1)'(1);

  assign terms = (b_part << b_shift) | (a_part << 1) | {{(PREV_W - 1){1'b0}}, a_k & b_k};

endmodule

// File: rtl/nonlinear_part.sv
// Iterative generator of the ANF product terms of a ripple carry chain,
// one bit level per clock, behind valid/ready handshakes.
module nonlinear_part
  import nl_pkg::*;
#(
  parameter int NBIT = NBIT_DFLT,
  parameter int NNL  = NNL_DFLT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            c_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NNL-1:0]  n,
  output logic [NBIT-1:0] a_q,
  output logic [NBIT-1:0] b_q,
  output logic            c_q
);

  localparam int PREV_W = 2 ** (NBIT + 1) - 1;
  localparam int LEN_W  = $clog2(PREV_W + 1);
  localparam int LVL_W  = (NBIT > 1) ? $clog2(NBIT) : 1;

  if (NNL != nnl_for(NBIT)) begin : g_nnl_bad
    $error("nonlinear_part: NNL inconsistent with NBIT");
  end

  state_t            state;
  logic [LVL_W-1:0]  lvl;
  logic [PREV_W-1:0] prev;
  logic [PREV_W-1:0] terms;
  logic [LEN_W-1:0]  prev_len;
  logic              a_bit;
  logic              b_bit;
  logic [NNL-1:0]    n_upd;
  logic [NNL-1:0]    lvl_field [NBIT];
  logic [NNL-1:0]    lvl_mask  [NBIT];

  assign a_bit = a_q[lvl];
  assign b_bit = b_q[lvl];

  nl_level_expand #(.PREV_W(PREV_W), .LEN_W(LEN_W)) u_expand (
    .a_k      (a_bit),
    .b_k      (b_bit),
    .prev     (prev),
    .prev_len (prev_len),
    .terms    (terms)
  );

  // Each level's slice of n, positioned at its fixed offset.
  for (genvar k = 0; k < NBIT; k++) begin : g_lvl
    localparam int OFF = lvl_off(k);
    localparam int LEN = lvl_len(k);
    assign lvl_mask[k]  = ((NNL'(1) << LEN) - NNL'(1)) << OFF;
    assign lvl_field[k] = NNL'(terms[LEN-1:0]) << OFF;
  end

  always_comb begin
    prev_len = LEN_W'(1);
    n_upd    = n;
    for (int k = 0; k < NBIT; k++) begin
      if (lvl == LVL_W'(k)) begin
        prev_len = LEN_W'(lvl_len(k - 1));
        n_upd    = (n & ~lvl_mask[k]) | lvl_field[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lvl       <= '0;
      n         <= '0;
      prev      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            c_q      <= c_in;
            n        <= '0;
            prev     <= PREV_W'(c_in);
            lvl      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          n    <= n_upd;
          prev <= terms;
          if (lvl == LVL_W'(NBIT - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lvl <= lvl + LVL_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonlinear_part.sv
// Directed and exhaustive bench for nonlinear_part with an XOR-reduce model of linear_part.
module tb_nonlinear_part;

  localparam int OFF [4] = '{0, 3, 10, 25};
  localparam int LEN [4] = '{3, 7, 15, 31};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        c_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [55:0] n;
  logic [3:0]  a_q;
  logic [3:0]  b_q;
  logic        c_q;

  int tests = 0;
  int fails = 0;

  nonlinear_part dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .a_q       (a_q),
    .b_q       (b_q),
    .c_q       (c_q)
  );

  always #5 clk = ~clk;

  // Term list built directly from the carry recurrence ordering.
  function automatic logic [55:0] ref_n(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    logic [30:0] t;
    logic [30:0] nt;
    logic [55:0] r;
    logic [3:0]  aa;
    logic [3:0]  bb;
    int          len;
    t = 31'(ic);
    len = 1;
    r = '0;
    aa = ia;
    bb = ib;
    for (int k = 0; k < 4; k++) begin
      nt = 31'(aa[0] & bb[0]);
      if (aa[0]) nt = nt | (t << 1);
      if (bb[0]) nt = nt | (t << (len + 1));
      r = r | (56'(nt) << OFF[k]);
      t = nt;
      len = 2 * len + 1;
      aa = aa >> 1;
      bb = bb >> 1;
    end
    return r;
  endfunction

  // linear_part: carry into bit k+1 is the XOR of level k's terms.
  function automatic logic [4:0] lin(input logic [55:0] nv, input logic [3:0] aq,
                                     input logic [3:0] bq, input logic cq);
    logic       c;
    logic [3:0] s;
    logic [3:0] aa;
    logic [3:0] bb;
    c = cq;
    s = '0;
    aa = aq;
    bb = bq;
    for (int k = 0; k < 4; k++) begin
      s = {aa[0] ^ bb[0] ^ c, s[3:1]};
      c = ^((nv >> OFF[k]) & ((56'd1 << LEN[k]) - 56'd1));
      aa = aa >> 1;
      bb = bb >> 1;
    end
    return {c, s};
  endfunction

  task automatic start_op(input logic [3:0] ia, input logic [3:0] ib, input logic ic, output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    c_in = ic;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    tests++;
    if (lat == 0) begin
      fails++;
      $display("FAIL op_timeout a=%h b=%h c=%0d: out_valid never rose", ia, ib, ic);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL out_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || n !== 56'h0 || a_q !== 4'h0 ||
        b_q !== 4'h0 || c_q !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ov=%b ir=%b n=%h a_q=%h b_q=%h c_q=%b, want 0 1 0 0 0 0",
               out_valid, in_ready, n, a_q, b_q, c_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                               input logic [55:0] exp_n, input logic [4:0] exp_sum);
    int lat;
    start_op(ia, ib, ic, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL latency a=%h b=%h c=%0d: got %0d cycles, want 4", ia, ib, ic, lat);
    end
    tests++;
    if (n !== exp_n) begin
      fails++;
      $display("FAIL n_directed a=%h b=%h c=%0d: got %h, want %h", ia, ib, ic, n, exp_n);
    end
    tests++;
    if (lin(n, a_q, b_q, c_q) !== exp_sum) begin
      fails++;
      $display("FAIL sum_directed a=%h b=%h c=%0d: got %h, want %h", ia, ib, ic,
               lin(n, a_q, b_q, c_q), exp_sum);
    end
    finish_op();
  endtask

  task automatic test_exhaustive();
    int lat;
    logic [4:0] exp_sum;
    for (int i = 0; i < 512; i++) begin
      start_op(4'(i >> 5), 4'(i >> 1), i[0], lat);
      exp_sum = 5'(i >> 5) + 5'((i >> 1) & 15) + 5'(i & 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      tests++;
      if (n !== ref_n(4'(i >> 5), 4'(i >> 1), i[0]) || lin(n, a_q, b_q, c_q) !== exp_sum) begin
        fails++;
        $display("FAIL exhaustive i=%0d: n=%h sum=%h, want n=%h sum=%h", i, n,
                 lin(n, a_q, b_q, c_q), ref_n(4'(i >> 5), 4'(i >> 1), i[0]), exp_sum);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [55:0] n0;
    start_op(4'hF, 4'h1, 1'b0, lat);
    n0 = n;
    @(negedge clk);
    a = 4'h3;
    b = 4'h5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || n !== n0 || a_q !== 4'hF || b_q !== 4'h1) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d: ov=%b ir=%b n=%h a_q=%h b_q=%h, want 1 0 %h F 1",
                 i, out_valid, in_ready, n, a_q, b_q, n0);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (lin(n, a_q, b_q, c_q) !== 5'h10) begin
      fails++;
      $display("FAIL stall_sum: got %h, want 10", lin(n, a_q, b_q, c_q));
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    a = 4'hB;
    b = 4'h6;
    c_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || n !== 56'h0 || in_ready !== 1'b1 || a_q !== 4'h0) begin
      fails++;
      $display("FAIL async_reset: ov=%b n=%h ir=%b a_q=%h, want 0 0 1 0", out_valid, n, in_ready, a_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(4'h7, 4'h9, 1'b1, lat);
    tests++;
    if (n !== ref_n(4'h7, 4'h9, 1'b1) || lin(n, a_q, b_q, c_q) !== 5'h11) begin
      fails++;
      $display("FAIL after_reset: n=%h sum=%h, want n=%h sum=11", n, lin(n, a_q, b_q, c_q),
               ref_n(4'h7, 4'h9, 1'b1));
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed(4'h0, 4'h0, 1'b0, 56'h0, 5'h00);
    test_directed(4'hF, 4'hF, 1'b1, 56'hFF_FFFF_FFFF_FFFF, 5'h1F);
    test_directed(4'h1, 4'h0, 1'b1, 56'h2, 5'h02);
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
